axis_fifo_wr_arb: RTL and testbench

Two-input, packet-level round-robin arbiter that shares the write side of the byte FIFO (`sync_fifo`, WIDTH=8) between two AXI-Stream sources, e.g. host command stream and loopback/status stream, ahead of the UART transmitter. A grant is held from first beat to `tlast`, so packets never interleave in the FIFO. Per-source completed-packet counters support status readback.

---
 rtl/axis_uart_pkg.sv | 18 +
 rtl/axis_pkt_counter.sv | 33 +++
 rtl/axis_fifo_wr_arb.sv | 134 +++++++++++++
 tb/tb_axis_fifo_wr_arb.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_uart_pkg.sv
// rtl/axis_uart_pkg.sv - shared encodings and defaults for the AXIS-to-UART write path
package axis_uart_pkg;

  // Default byte-stream width, matching the downstream FIFO.
  localparam int DEFAULT_WIDTH = 8;

  // Arbiter state encoding; the grant states double as the one-hot grant vector.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] GNT0 = 2'b01;
  localparam logic [1:0] GNT1 = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_GNT0 = GNT0,
    S_GNT1 = GNT1
  } arb_state_e;

endpackage

// File: rtl/axis_pkt_counter.sv
// rtl/axis_pkt_counter.sv - wrapping completed-packet counter
module axis_pkt_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Advance by one per completed packet; natural wrap at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register, cleared by the shared reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/axis_fifo_wr_arb.sv
// rtl/axis_fifo_wr_arb.sv - packet-level round-robin arbiter onto the byte FIFO write port
module axis_fifo_wr_arb
  import axis_uart_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s0_tdata,
  input  logic             s0_tvalid,
  input  logic             s0_tlast,
  output logic             s0_tready,
  input  logic [WIDTH-1:0] s1_tdata,
  input  logic             s1_tvalid,
  input  logic             s1_tlast,
  output logic             s1_tready,
  output logic [WIDTH-1:0] fifo_din,
  output logic             fifo_din_last,
  output logic             fifo_wr_en,
  input  logic             fifo_full,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       rr_q;
  logic       rr_d;
  logic       done0;
  logic       done1;

  // Owner state and round-robin preference; reset returns to idle preferring source 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // Arbitration, combinational write path of the owner, and packet-boundary re-arbitration.
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    s0_tready     = 1'b0;
    s1_tready     = 1'b0;
    fifo_wr_en    = 1'b0;
    fifo_din      = '0;
    fifo_din_last = 1'b0;
    done0         = 1'b0;
    done1         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s0_tvalid && s1_tvalid) begin
          state_d = rr_q ? S_GNT1 : S_GNT0;
        end else if (s0_tvalid) begin
          state_d = S_GNT0;
        end else if (s1_tvalid) begin
          state_d = S_GNT1;
        end
      end

      S_GNT0: begin
        s0_tready     = !fifo_full;
        fifo_wr_en    = s0_tvalid && !fifo_full;
        fifo_din      = s0_tdata;
        fifo_din_last = s0_tlast;
        // Packet done: hand preference to source 1 and re-arbitrate without a bubble.
        if (fifo_wr_en && s0_tlast) begin
          done0 = 1'b1;
          rr_d  = 1'b1;
          if (s1_tvalid) begin
            state_d = S_GNT1;
          end else if (s0_tvalid) begin
            state_d = S_GNT0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_GNT1: begin
        s1_tready     = !fifo_full;
        fifo_wr_en    = s1_tvalid && !fifo_full;
        fifo_din      = s1_tdata;
        fifo_din_last = s1_tlast;
        // Packet done: hand preference to source 0 and re-arbitrate without a bubble.
        if (fifo_wr_en && s1_tlast) begin
          done1 = 1'b1;
          rr_d  = 1'b0;
          if (s0_tvalid) begin
            state_d = S_GNT0;
          end else if (s1_tvalid) begin
            state_d = S_GNT1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign grant = state_q;
  assign busy  = |grant;

  axis_pkt_counter #(
    .CNT_W(CNT_W)
  ) u_cnt0 (
    .clk  (clk),
    .rst  (rst),
    .inc_i(done0),
    .cnt_o(pkt_cnt0)
  );

  axis_pkt_counter #(
    .CNT_W(CNT_W)
  ) u_cnt1 (
    .clk  (clk),
    .rst  (rst),
    .inc_i(done1),
    .cnt_o(pkt_cnt1)
  );

endmodule

// File: tb/tb_axis_fifo_wr_arb.sv
// tb/tb_axis_fifo_wr_arb.sv - scoreboard bench for the two-source FIFO write arbiter
module tb_axis_fifo_wr_arb;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;
  localparam int CNT_S = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] s0_tdata;
  logic             s0_tvalid;
  logic             s0_tlast;
  logic [WIDTH-1:0] s1_tdata;
  logic             s1_tvalid;
  logic             s1_tlast;
  logic             fifo_full;
  logic             full_next;

  logic             s0_tready, s1_tready, fifo_din_last, fifo_wr_en, busy;
  logic [WIDTH-1:0] fifo_din;
  logic [1:0]       grant;
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

  logic             w4_s0_tready, w4_s1_tready, w4_fifo_din_last, w4_fifo_wr_en, w4_busy;
  logic [WIDTH-1:0] w4_fifo_din;
  logic [1:0]       w4_grant;
  logic [CNT_S-1:0] w4_pkt_cnt0, w4_pkt_cnt1;

  // beat = {last, data}; expected write = {src, last, data}
  logic [8:0] srcq0[$];
  logic [8:0] srcq1[$];
  logic [9:0] expq[$];
  logic       acc0, acc1;
  logic [9:0] e_beat, g_beat;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axis_fifo_wr_arb #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .fifo_din(fifo_din), .fifo_din_last(fifo_din_last), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .grant(grant), .busy(busy),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  axis_fifo_wr_arb #(.WIDTH(WIDTH), .CNT_W(CNT_S)) dut_w4 (
    .clk(clk), .rst(rst),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(w4_s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(w4_s1_tready),
    .fifo_din(w4_fifo_din), .fifo_din_last(w4_fifo_din_last), .fifo_wr_en(w4_fifo_wr_en),
    .fifo_full(fifo_full), .grant(w4_grant), .busy(w4_busy),
    .pkt_cnt0(w4_pkt_cnt0), .pkt_cnt1(w4_pkt_cnt1)
  );

  // One clock: sources advance after the edge, outputs are sampled and scoreboarded at negedge.
  task automatic step_cycle();
    @(posedge clk);
    #1;
    if (acc0 && srcq0.size() != 0) srcq0.delete(0);
    if (acc1 && srcq1.size() != 0) srcq1.delete(0);
    acc0 = 1'b0;
    acc1 = 1'b0;
    fifo_full = full_next;
    if (srcq0.size() != 0) begin
      s0_tvalid = 1'b1; {s0_tlast, s0_tdata} = srcq0[0];
    end else begin
      s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tdata = '0;
    end
    if (srcq1.size() != 0) begin
      s1_tvalid = 1'b1; {s1_tlast, s1_tdata} = srcq1[0];
    end else begin
      s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = '0;
    end
    @(negedge clk);
    acc0 = s0_tvalid && s0_tready;
    acc1 = s1_tvalid && s1_tready;
    if (!rst && fifo_wr_en) begin
      n_cmp++;
      g_beat = {grant[1], fifo_din_last, fifo_din};
      if (expq.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got write %h, required no write", g_beat);
      end else begin
        e_beat = expq.pop_front();
        if (g_beat !== e_beat) begin
          n_err++;
          $display("FAIL sb_beat: got {src,last,din}=%h, required %h", g_beat, e_beat);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    srcq0.delete(); srcq1.delete(); expq.delete();
    acc0 = 1'b0; acc1 = 1'b0;
    full_next = 1'b0; fifo_full = 1'b0;
    s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tdata = '0;
    s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s0_tvalid = 1'b1; s0_tdata = 8'hAA; s0_tlast = 1'b1;
    s1_tvalid = 1'b1; s1_tdata = 8'h55; s1_tlast = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({grant, busy, s0_tready, s1_tready, fifo_wr_en} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got grant/busy/rdy0/rdy1/wr=%b, required 000000",
               {grant, busy, s0_tready, s1_tready, fifo_wr_en});
    end
    n_cmp++;
    if ({fifo_din, fifo_din_last} !== 9'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h, required 000", {fifo_din, fifo_din_last});
    end
    n_cmp++;
    if (pkt_cnt0 !== 16'd0 || pkt_cnt1 !== 16'd0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d/%0d, required 0/0", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_single_packet();
    do_reset();
    expq.push_back({1'b0, 1'b0, 8'h11});
    expq.push_back({1'b0, 1'b0, 8'h22});
    expq.push_back({1'b0, 1'b1, 8'h33});
    srcq0.push_back({1'b0, 8'h11});
    srcq0.push_back({1'b0, 8'h22});
    srcq0.push_back({1'b1, 8'h33});
    step_cycle();
    n_cmp++;
    if (grant !== 2'b00 || s0_tready !== 1'b0) begin
      n_err++;
      $display("FAIL arb_latency: got grant=%b rdy0=%b, required 00/0", grant, s0_tready);
    end
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      n_cmp++;
      if (grant !== 2'b01 || fifo_wr_en !== 1'b1 || fifo_din_last !== (i == 2)) begin
        n_err++;
        $display("FAIL single_beat%0d: got grant=%b wr=%b last=%b, required 01/1/%0d",
                 i, grant, fifo_wr_en, fifo_din_last, (i == 2));
      end
    end
    step_cycle();
    n_cmp++;
    if (fifo_wr_en !== 1'b0 || pkt_cnt0 !== 16'd1 || expq.size() != 0) begin
      n_err++;
      $display("FAIL single_done: got wr=%b cnt0=%0d left=%0d, required 0/1/0",
               fifo_wr_en, pkt_cnt0, expq.size());
    end
  endtask

  task automatic test_back_to_back();
    int first;
    int last;
    int nw;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      srcq0.push_back({1'b0, 8'hA0 + 8'(2 * k)});
      srcq0.push_back({1'b1, 8'hA1 + 8'(2 * k)});
      srcq1.push_back({1'b0, 8'hB0 + 8'(2 * k)});
      srcq1.push_back({1'b1, 8'hB1 + 8'(2 * k)});
      expq.push_back({1'b0, 1'b0, 8'hA0 + 8'(2 * k)});
      expq.push_back({1'b0, 1'b1, 8'hA1 + 8'(2 * k)});
      expq.push_back({1'b1, 1'b0, 8'hB0 + 8'(2 * k)});
      expq.push_back({1'b1, 1'b1, 8'hB1 + 8'(2 * k)});
    end
    first = -1; last = -1; nw = 0;
    for (int c = 0; c < 60 && nw < 16; c++) begin
      step_cycle();
      if (fifo_wr_en) begin
        if (first < 0) first = c;
        last = c;
        nw++;
      end
    end
    n_cmp++;
    if (nw != 16 || (last - first) != 15) begin
      n_err++;
      $display("FAIL b2b_bubble: got %0d writes over %0d cycles, required 16 over 16",
               nw, last - first + 1);
    end
    step_cycle();
    n_cmp++;
    if (pkt_cnt0 !== 16'd4 || pkt_cnt1 !== 16'd4 || expq.size() != 0) begin
      n_err++;
      $display("FAIL b2b_counts: got %0d/%0d left=%0d, required 4/4/0",
               pkt_cnt0, pkt_cnt1, expq.size());
    end
  endtask

  task automatic test_mid_packet();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      srcq1.push_back({(i == 3), 8'hC0 + 8'(i)});
      expq.push_back({1'b1, (i == 3), 8'hC0 + 8'(i)});
    end
    expq.push_back({1'b0, 1'b0, 8'hD0});
    expq.push_back({1'b0, 1'b1, 8'hD1});
    for (int k = 0; k < 10; k++) begin
      step_cycle();
      if (fifo_wr_en) break;
    end
    n_cmp++;
    if (fifo_wr_en !== 1'b1) begin
      n_err++;
      $display("FAIL mid_start: got no write within bound, required a write");
    end
    srcq0.push_back({1'b0, 8'hD0});
    srcq0.push_back({1'b1, 8'hD1});
    for (int i = 1; i < 6; i++) begin
      step_cycle();
      n_cmp++;
      if (fifo_wr_en !== 1'b1 || grant !== ((i < 4) ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL mid_beat%0d: got wr=%b grant=%b, required 1/%b",
                 i, fifo_wr_en, grant, (i < 4) ? 2'b10 : 2'b01);
      end
    end
    n_cmp++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL mid_left: got %0d pending, required 0", expq.size());
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      srcq0.push_back({(i == 3), 8'h41 + 8'(i)});
      expq.push_back({1'b0, (i == 3), 8'h41 + 8'(i)});
    end
    for (int k = 0; k < 10; k++) begin
      step_cycle();
      if (fifo_wr_en) break;
    end
    full_next = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step_cycle();
      n_cmp++;
      if (s0_tready !== 1'b0 || fifo_wr_en !== 1'b0 || grant !== 2'b01) begin
        n_err++;
        $display("FAIL full_hold%0d: got rdy0=%b wr=%b grant=%b, required 0/0/01",
                 i, s0_tready, fifo_wr_en, grant);
      end
    end
    full_next = 1'b0;
    step_cycle();
    n_cmp++;
    if (s0_tready !== 1'b1 || fifo_wr_en !== 1'b1 || fifo_din !== 8'h42) begin
      n_err++;
      $display("FAIL full_release: got rdy0=%b wr=%b din=%h, required 1/1/42",
               s0_tready, fifo_wr_en, fifo_din);
    end
    step_cycle();
    step_cycle();
    step_cycle();
    n_cmp++;
    if (pkt_cnt0 !== 16'd1 || expq.size() != 0) begin
      n_err++;
      $display("FAIL full_done: got cnt0=%0d left=%0d, required 1/0", pkt_cnt0, expq.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    int nw;
    do_reset();
    srcq0.push_back({1'b0, 8'h61});
    srcq0.push_back({1'b1, 8'h62});
    for (int i = 0; i < 4; i++) srcq0.push_back({(i == 3), 8'h51 + 8'(i)});
    expq.push_back({1'b0, 1'b0, 8'h61});
    expq.push_back({1'b0, 1'b1, 8'h62});
    expq.push_back({1'b0, 1'b0, 8'h51});
    nw = 0;
    for (int k = 0; k < 20 && nw < 3; k++) begin
      step_cycle();
      if (fifo_wr_en) nw++;
    end
    n_cmp++;
    if (nw != 3 || pkt_cnt0 !== 16'd1) begin
      n_err++;
      $display("FAIL rstmid_pre: got writes=%0d cnt0=%0d, required 3/1", nw, pkt_cnt0);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({grant, busy, s0_tready, s1_tready, fifo_wr_en, fifo_din_last, fifo_din} !== 15'h0) begin
      n_err++;
      $display("FAIL rstmid_outs: got %h, required 0000",
               {grant, busy, s0_tready, s1_tready, fifo_wr_en, fifo_din_last, fifo_din});
    end
    n_cmp++;
    if (pkt_cnt0 !== 16'd0 || pkt_cnt1 !== 16'd0) begin
      n_err++;
      $display("FAIL rstmid_cnt: got %0d/%0d, required 0/0", pkt_cnt0, pkt_cnt1);
    end
    do_reset();
    srcq0.push_back({1'b1, 8'h71});
    srcq1.push_back({1'b1, 8'h72});
    expq.push_back({1'b0, 1'b1, 8'h71});
    expq.push_back({1'b1, 1'b1, 8'h72});
    step_cycle();
    step_cycle();
    n_cmp++;
    if (grant !== 2'b01) begin
      n_err++;
      $display("FAIL rstmid_pref: got grant=%b, required 01", grant);
    end
    step_cycle();
    step_cycle();
    n_cmp++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL rstmid_left: got %0d pending, required 0", expq.size());
    end
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      srcq1.push_back({1'b1, 8'h80 + 8'(i)});
      expq.push_back({1'b1, 1'b1, 8'h80 + 8'(i)});
    end
    for (int k = 0; k < 40 && expq.size() != 0; k++) step_cycle();
    step_cycle();
    n_cmp++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL wrap_timeout: got %0d pending, required 0", expq.size());
    end
    n_cmp++;
    if (w4_pkt_cnt1 !== 4'd0 || pkt_cnt1 !== 16'd16) begin
      n_err++;
      $display("FAIL wrap_cnt: got w4=%0d w16=%0d, required 0/16", w4_pkt_cnt1, pkt_cnt1);
    end
  endtask

  initial begin
    rst = 1'b1;
    full_next = 1'b0; fifo_full = 1'b0;
    acc0 = 1'b0; acc1 = 1'b0;
    s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tdata = '0;
    s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = '0;
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_mid_packet();
    test_fifo_full();
    test_reset_mid_packet();
    test_cnt_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required completion");
    $fatal(1);
  end

endmodule
